nbody_pair_sched: RTL and testbench

Sequencer for the n-body integration datapath. On each run it steps through `num_steps` timesteps, and each timestep has two phases. In the acceleration phase it issues every (i, j) body pair to the acceleration/velocity pipeline, one pair per cycle. In the position phase it issues every body index to the position adder. It delays each issued address through shift registers matched to the datapath latency, so write-back addresses and enables line up with the results. It sits between the software register file (start/done/ack) and the body RAMs and arithmetic units.

---
 rtl/nbody_pair_sched_if.sv | 51 +++++
 rtl/nbody_pair_sched.sv | 229 ++++++++++++++++++++++
 tb/tb_nbody_pair_sched.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/nbody_pair_sched_if.sv
// Handshake and issue bus between the software register file, the
// n-body pair scheduler and the body RAM / arithmetic datapath.
interface nbody_pair_sched_if #(
  parameter int BODY_ADDR_WIDTH = 9
);
  // software control
  logic                       start;
  logic                       abort;
  logic                       ack;
  logic [BODY_ADDR_WIDTH:0]   num_bodies;
  logic [15:0]                num_steps;
  // software status
  logic                       busy;
  logic                       done;
  logic                       err;
  logic                       first_step;
  logic [15:0]                step_count;
  // acceleration-phase issue bus
  logic                       pair_valid;
  logic [BODY_ADDR_WIDTH-1:0] pair_i;
  logic [BODY_ADDR_WIDTH-1:0] pair_j;
  logic                       pair_self;
  // acceleration-phase write-back bus
  logic                       acc_valid;
  logic [BODY_ADDR_WIDTH-1:0] acc_i;
  logic [BODY_ADDR_WIDTH-1:0] acc_j;
  logic                       acc_self;
  // position-phase read and write-back
  logic                       pos_rd_valid;
  logic [BODY_ADDR_WIDTH-1:0] pos_rd_addr;
  logic                       pos_wr_valid;
  logic [BODY_ADDR_WIDTH-1:0] pos_wr_addr;

  // controller side: software registers
  modport master (
    output start, abort, ack, num_bodies, num_steps,
    input  busy, done, err, first_step, step_count,
    input  pair_valid, pair_i, pair_j, pair_self,
    input  acc_valid, acc_i, acc_j, acc_self,
    input  pos_rd_valid, pos_rd_addr, pos_wr_valid, pos_wr_addr
  );

  // scheduler side
  modport slave (
    input  start, abort, ack, num_bodies, num_steps,
    output busy, done, err, first_step, step_count,
    output pair_valid, pair_i, pair_j, pair_self,
    output acc_valid, acc_i, acc_j, acc_self,
    output pos_rd_valid, pos_rd_addr, pos_wr_valid, pos_wr_addr
  );
endinterface

// File: rtl/nbody_pair_sched.sv
// N-body pair scheduler: per timestep, issues all (i, j) pairs to the
// acceleration pipeline, then all body indices to the position adder, and
// delays each issue to line up write-back addresses with datapath results.
module nbody_pair_sched #(
  parameter int BODIES          = 512,
  parameter int BODY_ADDR_WIDTH = $clog2(BODIES),
  parameter int MIN_BODIES      = 21,
  parameter int ACCL_LATENCY    = 99,
  parameter int POS_LATENCY     = 20
) (
  input logic clk,
  input logic rst,
  nbody_pair_sched_if.slave bus
);

  localparam int BAW = BODY_ADDR_WIDTH;
  localparam int ACC_W = 2 * BAW + 2;
  localparam int POS_W = BAW + 1;
  localparam logic [BAW:0] MIN_N = (BAW + 1)'(MIN_BODIES);
  localparam logic [BAW:0] MAX_N = (BAW + 1)'(BODIES);

  typedef enum logic [2:0] {
    IDLE,
    ACCEL,
    ACCEL_DRAIN,
    POS,
    POS_DRAIN,
    DONE
  } state_t;

  state_t           state_q;
  logic [BAW:0]     n_last_q;
  logic [15:0]      step_last_q;
  logic [15:0]      step_count_q;
  logic             first_step_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic             pair_valid_q;
  logic [BAW-1:0]   pair_i_q;
  logic [BAW-1:0]   pair_j_q;
  logic             pair_self_q;
  logic             pos_rd_valid_q;
  logic [BAW-1:0]   pos_rd_addr_q;

  // delay lines: {valid, self, i, j} and {valid, addr}
  logic [ACC_W-1:0] acc_pipe_q [ACCL_LATENCY];
  logic [POS_W-1:0] pos_pipe_q [POS_LATENCY];

  logic             acc_valid;
  logic             acc_self;
  logic [BAW-1:0]   acc_i;
  logic [BAW-1:0]   acc_j;
  logic             pos_wr_valid;
  logic [BAW-1:0]   pos_wr_addr;

  logic [BAW-1:0]   pair_i_d;
  logic [BAW-1:0]   pair_j_d;
  logic [BAW-1:0]   pos_rd_addr_d;
  logic             pair_last;
  logic             pos_last;
  logic             acc_final;
  logic             wr_final;
  logic             start_ok;
  logic             step_final;

  assign {acc_valid, acc_self, acc_i, acc_j} = acc_pipe_q[ACCL_LATENCY-1];
  assign {pos_wr_valid, pos_wr_addr}         = pos_pipe_q[POS_LATENCY-1];

  // Loop-advance values and the end-of-phase detectors the FSM steers on.
  always_comb begin
    pair_i_d      = pair_i_q;
    pair_j_d      = pair_j_q + 1'b1;
    pair_last     = 1'b0;
    pos_rd_addr_d = pos_rd_addr_q + 1'b1;
    if ({1'b0, pair_j_q} == n_last_q) begin
      pair_j_d  = '0;
      pair_i_d  = pair_i_q + 1'b1;
      pair_last = ({1'b0, pair_i_q} == n_last_q);
    end
    pos_last   = ({1'b0, pos_rd_addr_q} == n_last_q);
    acc_final  = acc_valid && ({1'b0, acc_i} == n_last_q) && ({1'b0, acc_j} == n_last_q);
    wr_final   = pos_wr_valid && ({1'b0, pos_wr_addr} == n_last_q);
    start_ok   = (bus.num_bodies >= MIN_N) && (bus.num_bodies <= MAX_N);
    step_final = (step_count_q == step_last_q);
  end

  // Sequencer FSM with registered status and issue outputs; abort overrides all.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      n_last_q       <= '0;
      step_last_q    <= '0;
      step_count_q   <= '0;
      first_step_q   <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
      pair_valid_q   <= 1'b0;
      pair_i_q       <= '0;
      pair_j_q       <= '0;
      pair_self_q    <= 1'b0;
      pos_rd_valid_q <= 1'b0;
      pos_rd_addr_q  <= '0;
    end else if (bus.abort) begin
      state_q        <= IDLE;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      pair_valid_q   <= 1'b0;
      pair_self_q    <= 1'b0;
      pos_rd_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (start_ok) begin
              n_last_q     <= bus.num_bodies - 1'b1;
              step_last_q  <= (bus.num_steps == 16'd0) ? 16'd0 : bus.num_steps - 16'd1;
              err_q        <= 1'b0;
              step_count_q <= '0;
              first_step_q <= 1'b1;
              busy_q       <= 1'b1;
              pair_valid_q <= 1'b1;
              pair_i_q     <= '0;
              pair_j_q     <= '0;
              pair_self_q  <= 1'b1;
              state_q      <= ACCEL;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ACCEL: begin
          if (pair_last) begin
            pair_valid_q <= 1'b0;
            pair_self_q  <= 1'b0;
            state_q      <= ACCEL_DRAIN;
          end else begin
            pair_i_q    <= pair_i_d;
            pair_j_q    <= pair_j_d;
            pair_self_q <= (pair_i_d == pair_j_d);
          end
        end
        ACCEL_DRAIN: begin
          if (acc_final) begin
            pos_rd_valid_q <= 1'b1;
            pos_rd_addr_q  <= '0;
            state_q        <= POS;
          end
        end
        POS: begin
          if (pos_last) begin
            pos_rd_valid_q <= 1'b0;
            state_q        <= POS_DRAIN;
          end else begin
            pos_rd_addr_q <= pos_rd_addr_d;
          end
        end
        POS_DRAIN: begin
          if (wr_final) begin
            if (step_final) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= DONE;
            end else begin
              step_count_q <= step_count_q + 16'd1;
              first_step_q <= 1'b0;
              pair_valid_q <= 1'b1;
              pair_i_q     <= '0;
              pair_j_q     <= '0;
              pair_self_q  <= 1'b1;
              state_q      <= ACCEL;
            end
          end
        end
        DONE: begin
          if (bus.ack) begin
            done_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Acceleration write-back delay line, flushed by abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < ACCL_LATENCY; s++) acc_pipe_q[s] <= '0;
    end else if (bus.abort) begin
      for (int s = 0; s < ACCL_LATENCY; s++) acc_pipe_q[s] <= '0;
    end else begin
      acc_pipe_q[0] <= {pair_valid_q, pair_self_q, pair_i_q, pair_j_q};
      for (int s = 1; s < ACCL_LATENCY; s++) acc_pipe_q[s] <= acc_pipe_q[s-1];
    end
  end

  // Position write-back delay line, flushed by abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < POS_LATENCY; s++) pos_pipe_q[s] <= '0;
    end else if (bus.abort) begin
      for (int s = 0; s < POS_LATENCY; s++) pos_pipe_q[s] <= '0;
    end else begin
      pos_pipe_q[0] <= {pos_rd_valid_q, pos_rd_addr_q};
      for (int s = 1; s < POS_LATENCY; s++) pos_pipe_q[s] <= pos_pipe_q[s-1];
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.err          = err_q;
  assign bus.first_step   = first_step_q;
  assign bus.step_count   = step_count_q;
  assign bus.pair_valid   = pair_valid_q;
  assign bus.pair_i       = pair_i_q;
  assign bus.pair_j       = pair_j_q;
  assign bus.pair_self    = pair_self_q;
  assign bus.acc_valid    = acc_valid;
  assign bus.acc_i        = acc_i;
  assign bus.acc_j        = acc_j;
  assign bus.acc_self     = acc_self;
  assign bus.pos_rd_valid = pos_rd_valid_q;
  assign bus.pos_rd_addr  = pos_rd_addr_q;
  assign bus.pos_wr_valid = pos_wr_valid;
  assign bus.pos_wr_addr  = pos_wr_addr;

endmodule

// File: tb/tb_nbody_pair_sched.sv
// Scoreboard bench for nbody_pair_sched with short datapath latencies:
// stimulus pushes timed expected events, a monitor pops and compares them.
module tb_nbody_pair_sched;

  localparam int LA  = 4;
  localparam int LP  = 2;
  localparam int BAW = 9;
  localparam int BIG = 1000000;

  typedef struct {
    int cyc;
    int a;
    int b;
    int step;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   runBase = 0;
  int   runPeriod = 0;
  int   runSteps = 0;
  logic prevDone = 1'b0;
  ev_t  pairQ[$];
  ev_t  accQ[$];
  ev_t  rdQ[$];
  ev_t  wrQ[$];
  ev_t  doneQ[$];
  ev_t  me;

  nbody_pair_sched_if #(.BODY_ADDR_WIDTH(BAW)) bus();

  nbody_pair_sched #(
    .BODIES(512),
    .BODY_ADDR_WIDTH(BAW),
    .MIN_BODIES(21),
    .ACCL_LATENCY(LA),
    .POS_LATENCY(LP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // cycle index: value seen after the n-th rising edge
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] packEv(int c, int a, int b, int s, int st, int f);
    return {24'(c), 12'(a), 12'(b), 4'(s), 8'(st), 4'(f)};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic failEvent(input string name, input int expCyc);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s at cycle %0d: expected event cycle %0d", name, cyc, expCyc);
  endtask

  // drive a legal start and push every event expected up to cutoff cycles after it
  task automatic applyStimulus(input int n, input int s, input int cutoff);
    int sEff, p, b, c;
    sEff = (s == 0) ? 1 : s;
    p = n * n + LA + n + LP;
    b = cyc;
    runBase = b;
    runPeriod = p;
    runSteps = sEff;
    bus.num_bodies = 10'(n);
    bus.num_steps = 16'(s);
    bus.start = 1'b1;
    for (int st = 0; st < sEff; st++) begin
      for (int idx = 0; idx < n * n; idx++) begin
        c = b + st * p + 1 + idx;
        if (c - b <= cutoff) pairQ.push_back('{c, idx / n, idx % n, st});
        if (c + LA - b <= cutoff) accQ.push_back('{c + LA, idx / n, idx % n, st});
      end
      for (int k = 0; k < n; k++) begin
        c = b + st * p + n * n + LA + 1 + k;
        if (c - b <= cutoff) rdQ.push_back('{c, k, 0, st});
        if (c + LP - b <= cutoff) wrQ.push_back('{c + LP, k, 0, st});
      end
    end
    c = b + sEff * p + 1;
    if (c - b <= cutoff) doneQ.push_back('{c, 0, 0, 0});
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic waitCyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_valids"}, 64'({bus.pair_valid, bus.acc_valid, bus.pos_rd_valid, bus.pos_wr_valid}), 64'd0);
    checkOutput({tag, "_status"}, 64'({bus.busy, bus.done, bus.err, bus.first_step, bus.step_count}), 64'd0);
    checkOutput({tag, "_pair"}, 64'({bus.pair_i, bus.pair_j, bus.pair_self}), 64'd0);
    checkOutput({tag, "_acc"}, 64'({bus.acc_i, bus.acc_j, bus.acc_self}), 64'd0);
    checkOutput({tag, "_pos"}, 64'({bus.pos_rd_addr, bus.pos_wr_addr}), 64'd0);
  endtask

  task automatic drainCheck(input string tag);
    checkOutput({tag, "_pair_left"}, 64'(pairQ.size()), 64'd0);
    checkOutput({tag, "_acc_left"}, 64'(accQ.size()), 64'd0);
    checkOutput({tag, "_rd_left"}, 64'(rdQ.size()), 64'd0);
    checkOutput({tag, "_wr_left"}, 64'(wrQ.size()), 64'd0);
    checkOutput({tag, "_done_left"}, 64'(doneQ.size()), 64'd0);
  endtask

  // full run to DONE, then ack six cycles after done rises
  task automatic fullRun(input string tag, input int n, input int s);
    int dc;
    applyStimulus(n, s, BIG);
    checkOutput({tag, "_busy_run"}, 64'(bus.busy), 64'd1);
    dc = runBase + runSteps * runPeriod + 1;
    waitCyc(dc);
    checkOutput({tag, "_done_rise"}, 64'({bus.done, bus.busy}), 64'b10);
    waitCyc(dc + 6);
    checkOutput({tag, "_done_held"}, 64'(bus.done), 64'd1);
    bus.ack = 1'b1;
    @(negedge clk);
    bus.ack = 1'b0;
    checkOutput({tag, "_done_clr"}, 64'({bus.done, bus.busy}), 64'b00);
    repeat (2) @(negedge clk);
    drainCheck(tag);
  endtask

  // scoreboard monitor: flush overdue events, pop and compare on every valid
  always @(negedge clk) begin
    if (!rst) begin
      while (pairQ.size() > 0 && pairQ[0].cyc < cyc) begin me = pairQ.pop_front(); failEvent("pair_missing", me.cyc); end
      while (accQ.size() > 0 && accQ[0].cyc < cyc) begin me = accQ.pop_front(); failEvent("acc_missing", me.cyc); end
      while (rdQ.size() > 0 && rdQ[0].cyc < cyc) begin me = rdQ.pop_front(); failEvent("rd_missing", me.cyc); end
      while (wrQ.size() > 0 && wrQ[0].cyc < cyc) begin me = wrQ.pop_front(); failEvent("wr_missing", me.cyc); end
      while (doneQ.size() > 0 && doneQ[0].cyc < cyc) begin me = doneQ.pop_front(); failEvent("done_missing", me.cyc); end
      if (bus.pair_valid) begin
        if (pairQ.size() == 0) failEvent("pair_unexpected", -1);
        else begin
          me = pairQ.pop_front();
          checkOutput("pair", packEv(cyc, int'(bus.pair_i), int'(bus.pair_j), int'(bus.pair_self),
                                     int'(bus.step_count), int'(bus.first_step)),
                      packEv(me.cyc, me.a, me.b, int'(me.a == me.b), me.step, int'(me.step == 0)));
        end
      end
      if (bus.acc_valid) begin
        if (accQ.size() == 0) failEvent("acc_unexpected", -1);
        else begin
          me = accQ.pop_front();
          checkOutput("acc", packEv(cyc, int'(bus.acc_i), int'(bus.acc_j), int'(bus.acc_self), 0, 0),
                      packEv(me.cyc, me.a, me.b, int'(me.a == me.b), 0, 0));
        end
      end
      if (bus.pos_rd_valid) begin
        if (rdQ.size() == 0) failEvent("rd_unexpected", -1);
        else begin
          me = rdQ.pop_front();
          checkOutput("pos_rd", packEv(cyc, int'(bus.pos_rd_addr), 0, 0, int'(bus.step_count), 0),
                      packEv(me.cyc, me.a, 0, 0, me.step, 0));
        end
      end
      if (bus.pos_wr_valid) begin
        if (wrQ.size() == 0) failEvent("wr_unexpected", -1);
        else begin
          me = wrQ.pop_front();
          checkOutput("pos_wr", packEv(cyc, int'(bus.pos_wr_addr), 0, 0, 0, 0),
                      packEv(me.cyc, me.a, 0, 0, 0, 0));
        end
      end
      if (bus.done && !prevDone) begin
        if (doneQ.size() == 0) failEvent("done_unexpected", -1);
        else begin
          me = doneQ.pop_front();
          checkOutput("done", 64'(cyc), 64'(me.cyc));
        end
      end
    end
    prevDone = bus.done;
  end

  initial begin
    int b;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.ack = 1'b0;
    bus.num_bodies = '0;
    bus.num_steps = '0;
    #1;
    checkAllZero("reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    fullRun("n21s1", 21, 1);
    fullRun("n21s3", 21, 3);
    fullRun("n21s0", 21, 0);

    // illegal body counts are rejected
    bus.num_bodies = 10'd20;
    bus.num_steps = 16'd1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput("err_n20", 64'({bus.err, bus.busy}), 64'b10);
    bus.num_bodies = 10'd513;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput("err_n513", 64'({bus.err, bus.busy}), 64'b10);
    repeat (3) @(negedge clk);

    // start together with abort: abort wins, err untouched
    bus.num_bodies = 10'd21;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    checkOutput("start_abort", 64'({bus.err, bus.busy, bus.pair_valid}), 64'b100);
    repeat (3) @(negedge clk);

    // legal start clears err; abort at cycle 100
    applyStimulus(21, 1, 100);
    b = runBase;
    checkOutput("err_cleared", 64'({bus.err, bus.busy}), 64'b01);
    waitCyc(b + 100);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    checkOutput("abort_cycle", 64'(cyc - b), 64'd101);
    checkOutput("abort_idle", 64'({bus.pair_valid, bus.acc_valid, bus.pos_rd_valid, bus.pos_wr_valid,
                                   bus.busy, bus.done}), 64'd0);
    repeat (8) @(negedge clk);
    drainCheck("abort");
    fullRun("restart", 21, 1);

    // asynchronous reset in POS_DRAIN
    applyStimulus(21, 1, 466);
    b = runBase;
    waitCyc(b + 466);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkAllZero("async_rst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    drainCheck("rst");
    @(negedge clk);
    fullRun("after_rst", 21, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // watchdog so the bench always ends
  initial begin
    #(100000 * 10);
    miscompares++;
    $display("[TB] FAIL watchdog at cycle %0d: run did not complete, expected completion", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
